boreal_sram_slv: RTL and testbench
==================================

Name: boreal_sram_slv

Overview:
Word-addressed SRAM responder serving the Boreal SoC engine-side SRAM protocol. It provides one read request port and one write request port; each uses level req plus address, answered by a one-cycle ack. Both ports share a single-port internal word array. Requests are arbitrated round-robin, and a configurable number of wait states is inserted. The block sits between the vector engine's SRAM master ports and on-chip data memory; a backdoor port allows preload and test.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two)
BASE_ADDR, 32'h0000_0000, byte address of word 0
WAIT_STATES, 0, extra cycles between grant and ack (0..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rd_req  input  1  read request; held high with rd_addr stable until rd_ack seen
rd_addr  input  32  read byte address
rd_data  output  32  read data; valid only in the rd_ack cycle
rd_ack  output  1  one-cycle read completion pulse
wr_req  input  1  write request; held high with wr_addr/wr_data stable until wr_ack
wr_addr  input  32  write byte address
wr_data  input  32  write data
wr_ack  output  1  one-cycle write completion pulse
err  output  1  pulses with rd_ack/wr_ack when the access was illegal
dbg_we  input  1  backdoor write strobe
dbg_addr  input  $clog2(DEPTH)  backdoor word index
dbg_wdata  input  32  backdoor write data

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: rd_data=0, rd_ack=0, wr_ack=0, err=0, state=IDLE, wait counter=0, last_grant=WRITE (so the first tie goes to read).
- Array contents are not reset. An arbitrary reset mid-operation abandons the access; an uncommitted write is never written.
- All outputs are registered.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE, arbitration:
  - Any req high in cycle T grants one port and latches its address (and wr_data for writes).
  - Both req high: grant the port opposite to last_grant, then update last_grant.
  - Next state: WAIT if WAIT_STATES>0, else ACK.
- WAIT: counts WAIT_STATES cycles, then goes to ACK. Requests arriving during WAIT are not sampled.
- ACK:
  - The ack pulse for the granted port is high in cycle T+1+WAIT_STATES.
  - Read: rd_data holds array[word] in that same cycle. The array is read synchronously at the WAIT→ACK (or IDLE→ACK) edge.
  - Write: the array updates at the end of the ACK cycle and is visible to any later-granted read.
- HOLD: exactly one cycle; all requests are ignored (the requester drops req the cycle after ack), then IDLE.
- Back-to-back throughput: one access per WAIT_STATES+3 cycles.
- Legality:
  - word = (addr-BASE_ADDR)>>2.
  - The access is illegal if addr[1:0]!=0 or (addr-BASE_ADDR) >= DEPTH*4, using unsigned compare so addresses below BASE_ADDR wrap large and are illegal.
  - An illegal access still acks at normal latency with err=1.
  - Illegal read returns rd_data=0. Illegal write leaves the array untouched.
- rd_data returns to 0 the cycle after rd_ack. It is never X outside ack.
- Backdoor:
  - dbg_we writes array[dbg_addr] in any state.
  - If it commits in the same cycle as a functional write to the same word, the functional write wins.
- A req deasserted before its ack is a protocol violation; the block completes the access regardless.

Test Plan:
- Reset, then dbg preload array[3]=0x11223344; rd_req with rd_addr=BASE+0xC, WAIT_STATES=0 → rd_ack in cycle T+1 with rd_data=0x11223344, err=0; rd_ack low at T+2 and T+3 (HOLD).
- wr_req addr=BASE+0x10 data=0xA5A5_0001, then rd_req same address → wr_ack at T+1; read returns 0xA5A5_0001.
- rd_req and wr_req asserted together from reset, held for four accesses → grant order read, write, read, write; exactly one ack per grant; no double ack.
- WAIT_STATES=3: read request → rd_ack exactly 4 cycles after the request cycle; err=0.
- rd_addr=BASE+DEPTH*4 and wr_addr=BASE+0x2 (misaligned) → ack with err=1; rd_data=0; array word 0 unchanged when checked via a later read.
- Assert rst_n=0 during a WAIT of a write to word 5 (old value 0x0) → all outputs 0 immediately; after reset, a read of word 5 returns 0x0.

Source files
------------

// File: rtl/boreal_sram_slv.sv
// Word-addressed SRAM responder: round-robin read/write request ports sharing one word array.
// Ack lands WAIT_STATES+1 cycles after grant, then one HOLD cycle; requests sampled only in IDLE.

module boreal_sram_slv #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_req,
    input  logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic                     rd_ack,
    input  logic                     wr_req,
    input  logic [31:0]              wr_addr,
    input  logic [31:0]              wr_data,
    output logic                     wr_ack,
    output logic                     err,
    input  logic                     dbg_we,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    input  logic [31:0]              dbg_wdata
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [32:0] LIMIT   = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           last_wr_q, last_wr_d;
    logic           gnt_wr_q, gnt_wr_d;
    logic [AW-1:0]  word_q, word_d;
    logic [31:0]    wdat_q, wdat_d;
    logic           bad_q, bad_d;
    logic [31:0]    rd_data_q, rd_data_d;
    logic           rd_ack_q, rd_ack_d;
    logic           wr_ack_q, wr_ack_d;
    logic           err_q, err_d;

    logic [31:0]    mem_q [DEPTH];

    logic           any_req;
    logic           pick_wr;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_off;
    logic           sel_bad;

    // Ties go to the port that did not win last; the offset wraps so addresses below base read as huge.
    assign any_req  = rd_req | wr_req;
    assign pick_wr  = wr_req && (!rd_req || !last_wr_q);
    assign sel_addr = pick_wr ? wr_addr : rd_addr;
    assign sel_off  = sel_addr - BASE_ADDR;
    assign sel_bad  = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_off} >= LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (any_req) state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
            S_WAIT: if (cnt_q == WS_LAST) state_d = S_ACK;
            S_ACK:  state_d = S_HOLD;
            S_HOLD: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = 4'd0;
        last_wr_d = last_wr_q;
        gnt_wr_d  = gnt_wr_q;
        word_d    = word_q;
        wdat_d    = wdat_q;
        bad_d     = bad_q;
        rd_ack_d  = 1'b0;
        wr_ack_d  = 1'b0;
        err_d     = 1'b0;
        rd_data_d = 32'd0;
        if (state_q == S_IDLE && any_req) begin
            last_wr_d = pick_wr;
            gnt_wr_d  = pick_wr;
            word_d    = sel_off[AW+1:2];
            wdat_d    = wr_data;
            bad_d     = sel_bad;
        end
        if (state_q == S_WAIT && state_d == S_WAIT) begin
            cnt_d = cnt_q + 4'd1;
        end
        // Acks and read data register on the edge that enters ACK, using the just-latched grant.
        if (state_d == S_ACK && state_q != S_ACK) begin
            rd_ack_d  = !gnt_wr_d;
            wr_ack_d  = gnt_wr_d;
            err_d     = bad_d;
            rd_data_d = (!gnt_wr_d && !bad_d) ? mem_q[word_d] : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            last_wr_q <= 1'b1;
            gnt_wr_q  <= 1'b0;
            word_q    <= '0;
            wdat_q    <= 32'd0;
            bad_q     <= 1'b0;
            rd_data_q <= 32'd0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            last_wr_q <= last_wr_d;
            gnt_wr_q  <= gnt_wr_d;
            word_q    <= word_d;
            wdat_q    <= wdat_d;
            bad_q     <= bad_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
            err_q     <= err_d;
        end
    end

    // Functional write is placed last so it overrides a same-cycle backdoor write to the same word.
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem_q[dbg_addr] <= dbg_wdata;
        end
        if (state_q == S_ACK && gnt_wr_q && !bad_q) begin
            mem_q[word_q] <= wdat_q;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign wr_ack  = wr_ack_q;
    assign err     = err_q;

endmodule

// File: tb/tb_boreal_sram_slv.sv
// Bench for boreal_sram_slv: two instances (0 and 3 wait states) driven in parallel,
// scoreboard queues filled by the drivers from an arithmetic memory model, drained by a monitor.

module tb_boreal_sram_slv;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          rd_req [2];
    logic [31:0]   rd_addr [2];
    logic          wr_req [2];
    logic [31:0]   wr_addr [2];
    logic [31:0]   wr_data [2];
    logic          dbg_we [2];
    logic [AW-1:0] dbg_addr [2];
    logic [31:0]   dbg_wdata [2];
    wire  [31:0]   rd_data [2];
    wire           rd_ack [2];
    wire           wr_ack [2];
    wire           err [2];

    boreal_sram_slv #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .rd_ack(rd_ack[0]),
        .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
        .err(err[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0])
    );

    boreal_sram_slv #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .rd_ack(rd_ack[1]),
        .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
        .err(err[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          is_wr;
        bit          err;
        logic [31:0] rdata;
        int          ack_cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_m [2][DEPTH];
    int          free_c [2];

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s[inst%0d] @cyc %0d: got %h, expected %h", name, k, cyc, got, want);
    endtask

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop(input int k, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '{0, 0, 32'd0, 0};
        if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    // Plain legality rule: aligned, and offset from base (unsigned, wrapping) inside the array.
    task automatic decode(input logic [31:0] addr, output bit bad, output int w);
        logic [31:0] off;
        off = addr - BASE;
        bad = (addr % 4 != 0) || (off >= 32'(DEPTH * 4));
        w   = int'(off / 4);
    endtask

    // Builds the expected response of one access granted at cycle g, and applies it to the model.
    task automatic expect_access(input int k, input bit is_wr, input logic [31:0] addr,
                                 input logic [31:0] data, input int g);
        exp_t e;
        bit   bad;
        int   w;
        decode(addr, bad, w);
        e.is_wr   = is_wr;
        e.err     = bad;
        e.rdata   = (!is_wr && !bad) ? mem_m[k][w] : 32'd0;
        e.ack_cyc = g + 1 + ws(k);
        if (is_wr && !bad) mem_m[k][w] = data;
        push(k, e);
    endtask

    task automatic mon(input int k);
        exp_t e;
        bit   ok;
        if (rd_ack[k] || wr_ack[k]) begin
            pop(k, e, ok);
            if (!ok) begin
                checks++;
                $display("FAIL spurious_ack[inst%0d] @cyc %0d: rd_ack=%b wr_ack=%b, expected no ack",
                         k, cyc, rd_ack[k], wr_ack[k]);
            end else begin
                chk("ack_kind", k, {62'd0, rd_ack[k], wr_ack[k]}, {62'd0, !e.is_wr, e.is_wr});
                chk("ack_err", k, {63'd0, err[k]}, {63'd0, e.err});
                chk("ack_rd_data", k, {32'd0, rd_data[k]}, {32'd0, e.rdata});
                chk("ack_cycle", k, 64'(cyc), 64'(e.ack_cyc));
            end
        end else begin
            chk("idle_err_rd_data", k, {31'd0, err[k], rd_data[k]}, 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) mon(k);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int k, input bit is_wr);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_wr ? wr_ack[k] : rd_ack[k]) && n < 200);
        if (!(is_wr ? wr_ack[k] : rd_ack[k])) begin
            checks++;
            $display("FAIL ack_timeout[inst%0d]: no %s ack within 200 cycles", k, is_wr ? "write" : "read");
        end
    endtask

    task automatic dbg_wr(input int k, input int w, input logic [31:0] d);
        dbg_we[k]    = 1'b1;
        dbg_addr[k]  = AW'(w);
        dbg_wdata[k] = d;
        mem_m[k][w]  = d;
        step();
        dbg_we[k] = 1'b0;
    endtask

    // One access from an otherwise idle requester; collide pulses the backdoor at the same word during the ack cycle.
    task automatic xact(input int k, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit collide);
        int g;
        bit bad;
        int w;
        g = (cyc > free_c[k]) ? cyc : free_c[k];
        free_c[k] = g + ws(k) + 3;
        expect_access(k, is_wr, addr, data, g);
        decode(addr, bad, w);
        if (is_wr) begin
            wr_req[k] = 1'b1; wr_addr[k] = addr; wr_data[k] = data;
        end else begin
            rd_req[k] = 1'b1; rd_addr[k] = addr;
        end
        wait_ack(k, is_wr);
        if (collide && is_wr && !bad) begin
            dbg_we[k] = 1'b1; dbg_addr[k] = AW'(w); dbg_wdata[k] = ~data;
        end
        step();
        rd_req[k] = 1'b0;
        wr_req[k] = 1'b0;
        dbg_we[k] = 1'b0;
    endtask

    // Both ports request together from reset: reads win the first tie, then grants alternate.
    task automatic contended(input int k);
        int          g;
        logic [31:0] d1;
        logic [31:0] d2;
        d1 = $urandom;
        d2 = $urandom;
        g  = (cyc > free_c[k]) ? cyc : free_c[k];
        expect_access(k, 1'b0, BASE + 32'h1C, 32'd0, g);
        expect_access(k, 1'b1, BASE + 32'h1C, d1, g + (ws(k) + 3));
        expect_access(k, 1'b0, BASE + 32'h1C, 32'd0, g + 2 * (ws(k) + 3));
        expect_access(k, 1'b1, BASE + 32'h20, d2, g + 3 * (ws(k) + 3));
        free_c[k] = g + 4 * (ws(k) + 3);
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    rd_req[k] = 1'b1; rd_addr[k] = BASE + 32'h1C;
                    wait_ack(k, 1'b0);
                    step();
                    rd_req[k] = 1'b0;
                    step();
                end
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    wr_req[k] = 1'b1;
                    wr_addr[k] = (j == 0) ? BASE + 32'h1C : BASE + 32'h20;
                    wr_data[k] = (j == 0) ? d1 : d2;
                    wait_ack(k, 1'b1);
                    step();
                    wr_req[k] = 1'b0;
                    step();
                end
            end
        join
    endtask

    task automatic run_seq(input int k);
        for (int w = 0; w < DEPTH; w++) begin
            dbg_wr(k, w, (w == 3) ? 32'h1122_3344 : (w == 5) ? 32'h0 : 32'($urandom));
        end
        contended(k);
        xact(k, 1'b0, BASE + 32'hC, 32'd0, 1'b0);
        xact(k, 1'b1, BASE + 32'h10, 32'hA5A5_0001, 1'b0);
        xact(k, 1'b0, BASE + 32'h10, 32'd0, 1'b0);
        xact(k, 1'b0, BASE + 32'(DEPTH * 4), 32'd0, 1'b0);
        xact(k, 1'b1, BASE + 32'h2, 32'hBAD0_BAD0, 1'b0);
        xact(k, 1'b0, BASE, 32'd0, 1'b0);
        xact(k, 1'b0, BASE - 32'h4, 32'd0, 1'b0);
        xact(k, 1'b1, BASE + 32'h24, 32'h600D_0009, 1'b1);
        xact(k, 1'b0, BASE + 32'h24, 32'd0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            int          w;
            int          kind;
            logic [31:0] a;
            repeat ($urandom_range(0, 2)) step();
            w = $urandom_range(0, DEPTH - 1);
            if (w == 5) w = 4;
            if ($urandom_range(0, 4) == 0) dbg_wr(k, w, $urandom);
            kind = $urandom_range(0, 9);
            case (kind)
                0:       a = BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
                1:       a = BASE + 32'(DEPTH * 4) + 32'(w * 4);
                2:       a = BASE - 32'((w + 1) * 4);
                default: a = BASE + 32'(w * 4);
            endcase
            xact(k, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rd_req[k] = 1'b0; rd_addr[k] = '0; wr_req[k] = 1'b0; wr_addr[k] = '0;
            wr_data[k] = '0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
            free_c[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("reset_outputs", k, {29'd0, rd_ack[k], wr_ack[k], err[k], rd_data[k]}, 64'd0);
        end
        rst_n = 1'b1;
        step();
        fork
            run_seq(0);
            run_seq(1);
        join

        // Reset while the 3-wait-state instance is in WAIT for a write to word 5.
        repeat (4) step();
        wr_req[1] = 1'b1; wr_addr[1] = BASE + 32'h14; wr_data[1] = 32'hDEAD_BEEF;
        step();
        step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midop_reset_outputs", k, {29'd0, rd_ack[k], wr_ack[k], err[k], rd_data[k]}, 64'd0);
        end
        wr_req[1] = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        free_c[0] = 0;
        free_c[1] = 0;
        step();
        chk("word5_model_unchanged", 1, {32'd0, mem_m[1][5]}, 64'd0);
        xact(1, 1'b0, BASE + 32'h14, 32'd0, 1'b0);
        xact(0, 1'b0, BASE + 32'h14, 32'd0, 1'b0);
        repeat (4) step();
        chk("queues_drained", 0, 64'(q0.size()), 64'd0);
        chk("queues_drained", 1, 64'(q1.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
